// File: rtl/evu_pkg.sv
// -----------------------------------------------------------------------------
// evu_pkg - shared definitions for the event-unit counter bank.
//
// Contents:
//   REG_W              width of the per-counter register field in addr
//   REG_*              register offsets inside one counter's window
//   evu_ctrl_t         CTRL register layout {sel, irq_en, edge_mode, en}
//   EVT_*              4-bit event select encodings shared with the evu mux
//   ctrl_to_reg/reg_to_ctrl  CTRL <-> bus word packing helpers
//
// Optional feature macro: EVU_SNAPSHOT_EN (widens the register field to
// 3 bits so that offset 4 can address the snapshot shadow register).
// -----------------------------------------------------------------------------
package evu_pkg;

`ifdef EVU_SNAPSHOT_EN
    localparam int REG_W = 3;
`else
    localparam int REG_W = 2;
`endif

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_THRESH = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_SNAP   = 3'd4;

    typedef struct packed {
        logic [3:0] sel;
        logic       irq_en;
        logic       edge_mode;
        logic       en;
    } evu_ctrl_t;

    localparam logic [3:0] EVT_ICACHE_MISS = 4'd2;
    localparam logic [3:0] EVT_DCACHE_MISS = 4'd3;
    localparam logic [3:0] EVT_IF_EMPTY    = 4'd15;

    // Bus view of CTRL: [0] en, [1] edge_mode, [2] irq_en, [3] reads 0, [7:4] sel.
    function automatic logic [7:0] ctrl_to_reg(input evu_ctrl_t c);
        return {c.sel, 1'b0, c.irq_en, c.edge_mode, c.en};
    endfunction

    function automatic evu_ctrl_t reg_to_ctrl(input logic [7:0] d);
        return '{sel: d[7:4], irq_en: d[2], edge_mode: d[1], en: d[0]};
    endfunction

endpackage

// File: rtl/evu_counter.sv
// -----------------------------------------------------------------------------
// evu_counter - one event counter slice: CTRL, COUNT, THRESH, STATUS flops,
// edge detection of the incoming event and sticky ovf/hit flag logic.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   debug_mode        blocks counting while high
//   ev                single-bit event from this slice's evu mux
//   wr_ctrl/count/thresh/status  one-cycle write strobes for this slice
//   wdata_ctrl        decoded CTRL write value
//   wdata_cnt         COUNT/THRESH write value
//   wdata_w1c         STATUS write-1-to-clear mask {hit, ovf}
//   ctrl, count, thresh, ovf, hit   current register contents
//   snapshot, snap    (EVU_SNAPSHOT_EN only) capture strobe and shadow value
// -----------------------------------------------------------------------------
module evu_counter
    import evu_pkg::*;
#(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_mode,
    input  logic             ev,
    input  logic             wr_ctrl,
    input  logic             wr_count,
    input  logic             wr_thresh,
    input  logic             wr_status,
    input  evu_ctrl_t        wdata_ctrl,
    input  logic [CNT_W-1:0] wdata_cnt,
    input  logic [1:0]       wdata_w1c,
`ifdef EVU_SNAPSHOT_EN
    input  logic             snapshot,
    output logic [CNT_W-1:0] snap,
`endif
    output evu_ctrl_t        ctrl,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] thresh,
    output logic             ovf,
    output logic             hit
);

    evu_ctrl_t        ctrl_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] thresh_r;
    logic             ovf_r;
    logic             hit_r;
    logic             ev_q_r;

    logic             inc_s;
    logic             ovf_set_s;
    logic             hit_set_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [CNT_W-1:0] count_next_s;

    assign count_inc_s = count_r + CNT_W'(1'b1);

    // Count qualification and next COUNT value; a COUNT write beats the increment.
    always_comb begin
        inc_s        = ctrl_r.en & ~debug_mode & ev & (~ctrl_r.edge_mode | ~ev_q_r);
        ovf_set_s    = 1'b0;
        hit_set_s    = 1'b0;
        count_next_s = count_r;
        if (wr_count) begin
            count_next_s = wdata_cnt;
        end else if (inc_s) begin
            count_next_s = count_inc_s;
            ovf_set_s    = &count_r;
            hit_set_s    = (thresh_r != {CNT_W{1'b0}}) && (count_inc_s == thresh_r);
        end else begin
            count_next_s = count_r;
        end
    end

    // Slice state: config, counter, threshold, sticky flags (clear wins over set).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r   <= evu_ctrl_t'(7'd0);
            count_r  <= {CNT_W{1'b0}};
            thresh_r <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
            hit_r    <= 1'b0;
            ev_q_r   <= 1'b0;
        end else begin
            ev_q_r  <= ev;
            count_r <= count_next_s;
            ovf_r   <= (ovf_r | ovf_set_s) & ~(wr_status & wdata_w1c[0]);
            hit_r   <= (hit_r | hit_set_s) & ~(wr_status & wdata_w1c[1]);
            if (wr_ctrl) begin
                ctrl_r <= wdata_ctrl;
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (wr_thresh) begin
                thresh_r <= wdata_cnt;
            end else begin
                thresh_r <= thresh_r;
            end
        end
    end

`ifdef EVU_SNAPSHOT_EN
    logic [CNT_W-1:0] snap_r;

    // Shadow copy of the post-update count, taken on the snapshot strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r <= {CNT_W{1'b0}};
        end else if (snapshot) begin
            snap_r <= count_next_s;
        end else begin
            snap_r <= snap_r;
        end
    end

    assign snap = snap_r;
`endif

    assign ctrl   = ctrl_r;
    assign count  = count_r;
    assign thresh = thresh_r;
    assign ovf    = ovf_r;
    assign hit    = hit_r;

endmodule

// File: rtl/evu_counter_bank.sv
// -----------------------------------------------------------------------------
// evu_counter_bank - NUM_CNT programmable event counters fed by evu muxes,
// with a single-cycle register interface and a level interrupt.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   debug_mode_i      freezes all counting
//   event_i[k]        output of evu mux k
//   sel_o[4k+3:4k]    select for evu mux k (straight from CTRL.sel)
//   req_i/we_i/addr_i/wdata_i   register access, addr = {index, reg}
//   rvalid_o/rdata_o  read response one cycle after a read request
//   irq_o             OR over counters of irq_en & (ovf | hit), registered
//   snapshot_i        (EVU_SNAPSHOT_EN only) capture all counts to SNAP_k
//
// Optional feature macro: EVU_SNAPSHOT_EN.
// -----------------------------------------------------------------------------
module evu_counter_bank
    import evu_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 48,
    parameter int DATA_W  = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              debug_mode_i,
    input  logic [NUM_CNT-1:0]                event_i,
    output logic [4*NUM_CNT-1:0]              sel_o,
    input  logic                              req_i,
    input  logic                              we_i,
    input  logic [$clog2(NUM_CNT)+REG_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]                 wdata_i,
`ifdef EVU_SNAPSHOT_EN
    input  logic                              snapshot_i,
`endif
    output logic                              rvalid_o,
    output logic [DATA_W-1:0]                 rdata_o,
    output logic                              irq_o
);

    localparam int AW = $clog2(NUM_CNT) + REG_W;

    logic [AW-1:0]      idx_s;
    logic [2:0]         reg_s;
    evu_ctrl_t          ctrl_s   [NUM_CNT];
    logic [CNT_W-1:0]   count_s  [NUM_CNT];
    logic [CNT_W-1:0]   thresh_s [NUM_CNT];
    logic [CNT_W-1:0]   snap_s   [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_s;
    logic [NUM_CNT-1:0] hit_s;
    logic [NUM_CNT-1:0] irq_src_s;
    logic [DATA_W-1:0]  word_s;
    logic [DATA_W-1:0]  rd_data_s;

    logic               rvalid_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               irq_r;

    assign idx_s = AW'(addr_i >> REG_W);
    assign reg_s = 3'(addr_i[REG_W-1:0]);

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        // An index beyond NUM_CNT matches no slice, so such writes vanish.
        logic wr_sel_s;
        assign wr_sel_s = req_i & we_i & (idx_s == AW'(k));

        evu_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .debug_mode (debug_mode_i),
            .ev         (event_i[k]),
            .wr_ctrl    (wr_sel_s & (reg_s == REG_CTRL)),
            .wr_count   (wr_sel_s & (reg_s == REG_COUNT)),
            .wr_thresh  (wr_sel_s & (reg_s == REG_THRESH)),
            .wr_status  (wr_sel_s & (reg_s == REG_STATUS)),
            .wdata_ctrl (reg_to_ctrl(wdata_i[7:0])),
            .wdata_cnt  (wdata_i[CNT_W-1:0]),
            .wdata_w1c  (wdata_i[1:0]),
`ifdef EVU_SNAPSHOT_EN
            .snapshot   (snapshot_i),
            .snap       (snap_s[k]),
`endif
            .ctrl       (ctrl_s[k]),
            .count      (count_s[k]),
            .thresh     (thresh_s[k]),
            .ovf        (ovf_s[k]),
            .hit        (hit_s[k])
        );

`ifndef EVU_SNAPSHOT_EN
        assign snap_s[k] = {CNT_W{1'b0}};
`endif

        assign sel_o[4*k +: 4] = ctrl_s[k].sel;
        assign irq_src_s[k]    = ctrl_s[k].irq_en & (ovf_s[k] | hit_s[k]);
    end

    // Read mux: one-hot OR over slices, so an out-of-range index reads 0.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        word_s    = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_CNT; k++) begin
            case (reg_s)
                REG_CTRL:   word_s = DATA_W'(ctrl_to_reg(ctrl_s[k]));
                REG_COUNT:  word_s = DATA_W'(count_s[k]);
                REG_THRESH: word_s = DATA_W'(thresh_s[k]);
                REG_STATUS: word_s = DATA_W'({hit_s[k], ovf_s[k]});
                REG_SNAP:   word_s = DATA_W'(snap_s[k]);
                default:    word_s = {DATA_W{1'b0}};
            endcase
            rd_data_s = rd_data_s | (word_s & {DATA_W{idx_s == AW'(k)}});
        end
    end

    // Read response (data held between reads) and registered interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            rvalid_r <= req_i & ~we_i;
            irq_r    <= |irq_src_s;
            if (req_i & ~we_i) begin
                rdata_r <= rd_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign rvalid_o = rvalid_r;
    assign rdata_o  = rdata_r;
    assign irq_o    = irq_r;

endmodule

// File: tb/tb_evu_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_evu_counter_bank - directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the counter bank.
// -----------------------------------------------------------------------------
module tb_evu_counter_bank;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 48;
    localparam int DATA_W  = 64;
`ifdef EVU_SNAPSHOT_EN
    localparam int RW = 3;
`else
    localparam int RW = 2;
`endif
    localparam int AW = $clog2(NUM_CNT) + RW;
    localparam longint unsigned MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 debug_mode_i;
    logic [NUM_CNT-1:0]   event_i;
    logic [4*NUM_CNT-1:0] sel_o;
    logic                 req_i;
    logic                 we_i;
    logic [AW-1:0]        addr_i;
    logic [DATA_W-1:0]    wdata_i;
    logic                 rvalid_o;
    logic [DATA_W-1:0]    rdata_o;
    logic                 irq_o;
`ifdef EVU_SNAPSHOT_EN
    logic                 snapshot_i;
`endif

    evu_counter_bank #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .debug_mode_i (debug_mode_i),
        .event_i      (event_i),
        .sel_o        (sel_o),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
`ifdef EVU_SNAPSHOT_EN
        .snapshot_i   (snapshot_i),
`endif
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one entry per counter.
    longint unsigned m_cnt  [NUM_CNT];
    longint unsigned m_thr  [NUM_CNT];
    longint unsigned m_snap [NUM_CNT];
    bit              m_en   [NUM_CNT];
    bit              m_edge [NUM_CNT];
    bit              m_ie   [NUM_CNT];
    bit [3:0]        m_sel  [NUM_CNT];
    bit              m_ovf  [NUM_CNT];
    bit              m_hit  [NUM_CNT];
    bit              m_prev [NUM_CNT];
    logic [63:0]     exp_rdata;
    bit              exp_rvalid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input int unsigned idx, input int unsigned rg);
        if (idx >= NUM_CNT) return 64'd0;
        case (rg)
            0: return {56'd0, m_sel[idx], 1'b0, m_ie[idx], m_edge[idx], m_en[idx]};
            1: return m_cnt[idx];
            2: return m_thr[idx];
            3: return {62'd0, m_hit[idx], m_ovf[idx]};
            4: return m_snap[idx];
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CNT; k++) begin
            m_cnt[k] = 0; m_thr[k] = 0; m_snap[k] = 0;
            m_en[k] = 0; m_edge[k] = 0; m_ie[k] = 0; m_sel[k] = 4'd0;
            m_ovf[k] = 0; m_hit[k] = 0; m_prev[k] = 0;
        end
        exp_rdata  = 64'd0;
        exp_rvalid = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge.
    task automatic cycle(input bit rq, input bit wr, input int unsigned addr,
                         input logic [63:0] wd, input logic [NUM_CNT-1:0] ev,
                         input bit dbg, input bit snap);
        int unsigned     idx;
        int unsigned     rg;
        bit              exp_irq;
        bit              inc;
        bit              wk;
        bit              oset;
        bit              hset;
        longint unsigned nc;
        logic [4*NUM_CNT-1:0] exp_sel;

        req_i = rq; we_i = wr; addr_i = AW'(addr); wdata_i = wd;
        event_i = ev; debug_mode_i = dbg;
`ifdef EVU_SNAPSHOT_EN
        snapshot_i = snap;
`endif
        idx = addr >> RW;
        rg  = addr & ((1 << RW) - 1);

        exp_irq = 1'b0;
        for (int k = 0; k < NUM_CNT; k++)
            if (m_ie[k] && (m_ovf[k] || m_hit[k])) exp_irq = 1'b1;
        exp_rvalid = rq && !wr;
        if (rq && !wr) exp_rdata = model_read(idx, rg);

        for (int k = 0; k < NUM_CNT; k++) begin
            inc  = m_en[k] && !dbg && ev[k] && (!m_edge[k] || !m_prev[k]);
            wk   = rq && wr && (idx == k);
            oset = 1'b0;
            hset = 1'b0;
            m_prev[k] = ev[k];
            if (wk && rg == 1) begin
                m_cnt[k] = wd & MASK;
            end else if (inc) begin
                nc = (m_cnt[k] + 1) & MASK;
                oset = (nc == 0);
                hset = (m_thr[k] != 0) && (nc == m_thr[k]);
                m_cnt[k] = nc;
            end
            m_ovf[k] = (m_ovf[k] || oset) && !(wk && rg == 3 && wd[0]);
            m_hit[k] = (m_hit[k] || hset) && !(wk && rg == 3 && wd[1]);
            if (wk && rg == 0) begin
                m_en[k] = wd[0]; m_edge[k] = wd[1]; m_ie[k] = wd[2]; m_sel[k] = wd[7:4];
            end
            if (wk && rg == 2) m_thr[k] = wd & MASK;
            if (snap) m_snap[k] = m_cnt[k];
        end

        @(posedge clk_i);
        #1;
        for (int k = 0; k < NUM_CNT; k++) exp_sel[4*k +: 4] = m_sel[k];
        check_eq("rvalid", 64'(rvalid_o), 64'(exp_rvalid));
        check_eq("rdata", rdata_o, exp_rdata);
        check_eq("irq", 64'(irq_o), 64'(exp_irq));
        check_eq("sel", 64'(sel_o), 64'(exp_sel));
        @(negedge clk_i);
    endtask

    task automatic wr_reg(input int k, input int rg, input logic [63:0] d, input logic [NUM_CNT-1:0] ev);
        cycle(1'b1, 1'b1, (k << RW) | rg, d, ev, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input int k, input int rg, input logic [NUM_CNT-1:0] ev);
        cycle(1'b1, 1'b0, (k << RW) | rg, 64'd0, ev, 1'b0, 1'b0);
    endtask

    task automatic run(input int n, input logic [NUM_CNT-1:0] ev, input bit dbg);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 64'd0, ev, dbg, 1'b0);
    endtask

    // Asynchronous reset asserted off the clock edge; outputs must clear at once.
    task automatic async_reset();
        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        event_i = '0; debug_mode_i = 1'b0;
`ifdef EVU_SNAPSHOT_EN
        snapshot_i = 1'b0;
`endif
        #1;
        check_eq("rst_irq", 64'(irq_o), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
        check_eq("rst_rdata", rdata_o, 64'd0);
        check_eq("rst_sel", 64'(sel_o), 64'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int unsigned r;
        int unsigned a;
        logic [63:0] d;

        async_reset();

        // Reset in the middle of counting.
        wr_reg(0, 0, 64'h05, 4'b0000);
        wr_reg(0, 2, 64'd2, 4'b0000);
        run(5, 4'b0001, 1'b0);
        check_eq("s1_irq_before_rst", 64'(irq_o), 64'd1);
        #2;
        async_reset();
        rd_reg(0, 1, 4'b0000);
        check_eq("s1_count0_after_rst", rdata_o, 64'd0);

        // Level versus edge mode on counter 1.
        wr_reg(1, 0, 64'hE1, 4'b0000);
        run(10, 4'b0010, 1'b0);
        rd_reg(1, 1, 4'b0000);
        check_eq("s2_level_count", rdata_o, 64'd10);
        check_eq("s2_sel1", 64'(sel_o[7:4]), 64'hE);
        wr_reg(1, 1, 64'd0, 4'b0000);
        wr_reg(1, 0, 64'hE3, 4'b0000);
        run(10, 4'b0010, 1'b0);
        rd_reg(1, 1, 4'b0000);
        check_eq("s2_edge_count", rdata_o, 64'd1);

        // Wrap on counter 2 with interrupt, then W1C.
        wr_reg(2, 0, 64'h05, 4'b0000);
        wr_reg(2, 1, 64'hFFFF_FFFF_FFFF, 4'b0000);
        run(1, 4'b0100, 1'b0);
        rd_reg(2, 1, 4'b0000);
        check_eq("s3_wrap_count", rdata_o, 64'd0);
        check_eq("s3_irq_set", 64'(irq_o), 64'd1);
        rd_reg(2, 3, 4'b0000);
        check_eq("s3_status_ovf", rdata_o, 64'd1);
        wr_reg(2, 3, 64'd1, 4'b0000);
        run(1, 4'b0000, 1'b0);
        check_eq("s3_irq_cleared", 64'(irq_o), 64'd0);

        // Threshold hit on counter 3, then THRESH = 0 never hits.
        wr_reg(3, 2, 64'd3, 4'b0000);
        wr_reg(3, 0, 64'h01, 4'b0000);
        run(2, 4'b1000, 1'b0);
        rd_reg(3, 3, 4'b1000);
        check_eq("s4_hit_not_yet", rdata_o, 64'd0);
        rd_reg(3, 3, 4'b0000);
        check_eq("s4_hit_set", rdata_o, 64'd2);
        rd_reg(3, 1, 4'b0000);
        check_eq("s4_count3", rdata_o, 64'd3);
        wr_reg(3, 3, 64'd2, 4'b0000);
        wr_reg(3, 1, 64'd0, 4'b0000);
        wr_reg(3, 2, 64'd0, 4'b0000);
        run(5, 4'b1000, 1'b0);
        rd_reg(3, 3, 4'b0000);
        check_eq("s4_thresh0_no_hit", rdata_o, 64'd0);

        // COUNT write colliding with a qualifying event.
        wr_reg(0, 0, 64'h01, 4'b0000);
        wr_reg(0, 1, 64'd100, 4'b0001);
        rd_reg(0, 1, 4'b0000);
        check_eq("s5_collision", rdata_o, 64'd100);
        check_eq("s5_rvalid", 64'(rvalid_o), 64'd1);

        // Debug mode freezes counting.
        run(4, 4'b1111, 1'b1);
        rd_reg(0, 1, 4'b0000);
        check_eq("s6_debug_frozen", rdata_o, 64'd100);

`ifdef EVU_SNAPSHOT_EN
        cycle(1'b0, 1'b0, 0, 64'd0, 4'b1111, 1'b0, 1'b1);
        rd_reg(0, 4, 4'b0000);
        check_eq("s7_snap0", rdata_o, 64'd101);
        for (int k = 1; k < NUM_CNT; k++) rd_reg(k, 4, 4'b0000);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, (1 << AW) - 1);
            d = {$urandom, $urandom};
            if (r < 4) begin
                cycle(1'b1, 1'b0, a, 64'd0, NUM_CNT'($urandom),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            end else if (r < 6) begin
                case (a & ((1 << RW) - 1))
                    1: d = (r == 4) ? (MASK - 64'($urandom_range(0, 3))) : 64'($urandom_range(0, 20));
                    2: d = 64'($urandom_range(0, 20));
                    default: d = d;
                endcase
                cycle(1'b1, 1'b1, a, d, NUM_CNT'($urandom),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            end else begin
                cycle(1'b0, 1'b0, a, d, NUM_CNT'($urandom),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
